// File: rtl/blake2_msg_pad_pkg.sv
// Shared BLAKE2 message-padding definitions: block geometry, length widths
// and the padder FSM state encoding.
package blake2_msg_pad_pkg;

    localparam int B2_BLOCK_BYTES = 64;
    localparam int B2_IDX_W       = 6;
    localparam int B2_KK_W        = 6;
    localparam int B2_LL_W        = 128;
    localparam int B2_MSG_CNT_W   = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEY   = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } pad_state_t;

endpackage

// File: rtl/blake2_blk_buf.sv
// One-block byte buffer with a zero-padding read port: bytes at or beyond
// the fill count read as 8'h00, so stale contents never need clearing.
module blake2_blk_buf
    import blake2_msg_pad_pkg::*;
#(
    parameter int BLOCK_BYTES = B2_BLOCK_BYTES,
    parameter int IDX_W       = B2_IDX_W
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [IDX_W:0]   fill_cnt,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [BLOCK_BYTES];

    // Byte storage; deliberately not reset, the fill count masks old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read mux: valid bytes pass through, the tail of the block is zero pad.
    always_comb begin
        rd_data = 8'h00;
        if ({1'b0, rd_idx} < fill_cnt) begin
            rd_data = mem[rd_idx];
        end
    end

endmodule

// File: rtl/blake2_msg_pad.sv
// BLAKE2 message padder: collects the optional key block and message bytes
// into 64-byte blocks, then streams each block (zero padded) to the core with
// first/last flags and the final byte count for the t counter.
module blake2_msg_pad
    import blake2_msg_pad_pkg::*;
#(
    parameter int BLOCK_BYTES = B2_BLOCK_BYTES,
    parameter int IDX_W       = B2_IDX_W,
    parameter int KK_W        = B2_KK_W,
    parameter int LL_W        = B2_LL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [KK_W-1:0]  kk_i,
    input  logic [KK_W-1:0]  nn_i,
    input  logic             empty_i,
    input  logic             in_v_i,
    output logic             in_ready_o,
    input  logic [7:0]       in_data_i,
    input  logic             in_last_i,
    input  logic             core_ready_i,
    output logic             data_v_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic [7:0]       data_o,
    output logic             block_first_o,
    output logic             block_last_o,
    output logic [KK_W-1:0]  kk_o,
    output logic [KK_W-1:0]  nn_o,
    output logic [LL_W-1:0]  ll_o
);

    localparam int MSG_W = B2_MSG_CNT_W;
    localparam int CMP_W = ((KK_W > IDX_W + 1) ? KK_W : IDX_W + 1) + 1;

    localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(BLOCK_BYTES);
    localparam logic [IDX_W:0]   ONE_CNT  = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [MSG_W-1:0] ONE_MSG  = MSG_W'(1);

    pad_state_t       state_q;
    pad_state_t       state_d;
    logic [IDX_W:0]   fill_cnt_q;
    logic [IDX_W:0]   fill_cnt_inc;
    logic [IDX_W-1:0] drain_idx_q;
    logic [KK_W-1:0]  kk_q;
    logic [KK_W-1:0]  nn_q;
    logic [MSG_W-1:0] msg_cnt_q;
    logic             empty_q;
    logic             first_q;
    logic             last_q;
    logic             accept;
    logic             key_done;
    logic             fill_full;
    logic             drain_at_end;
    logic [7:0]       buf_rd;

    assign fill_cnt_inc = fill_cnt_q + ONE_CNT;
    assign accept       = in_v_i & in_ready_o;
    // Key phase ends on the byte that brings the count up to kk.
    assign key_done     = (CMP_W'(fill_cnt_inc) == CMP_W'(kk_q));
    assign fill_full    = (fill_cnt_inc == FULL_CNT);
    assign drain_at_end = (drain_idx_q == LAST_IDX);

    assign data_idx_o = drain_idx_q;
    assign kk_o       = kk_q;
    assign nn_o       = nn_q;
    // Final t value: message bytes plus one full block when a key was used.
    assign ll_o       = LL_W'(msg_cnt_q) + ((kk_q != '0) ? LL_W'(BLOCK_BYTES) : '0);

    blake2_blk_buf #(
        .BLOCK_BYTES (BLOCK_BYTES),
        .IDX_W       (IDX_W)
    ) u_buf (
        .clk      (clk),
        .wr_en    (accept),
        .wr_idx   (fill_cnt_q[IDX_W-1:0]),
        .wr_data  (in_data_i),
        .rd_idx   (drain_idx_q),
        .fill_cnt (fill_cnt_q),
        .rd_data  (buf_rd)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/output decode.
    always_comb begin
        state_d       = state_q;
        in_ready_o    = 1'b0;
        data_v_o      = 1'b0;
        data_o        = 8'h00;
        block_first_o = 1'b0;
        block_last_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (kk_i != '0) begin
                        state_d = ST_KEY;
                    end else if (empty_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_KEY: begin
                in_ready_o = 1'b1;
                if (in_v_i && key_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FILL: begin
                in_ready_o = 1'b1;
                if (in_v_i && (in_last_i || fill_full)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                data_v_o      = core_ready_i;
                data_o        = buf_rd;
                block_first_o = first_q;
                block_last_o  = last_q;
                if (core_ready_i && drain_at_end) begin
                    state_d = last_q ? ST_IDLE : ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latched lengths, fill/drain/message counters and block flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kk_q        <= '0;
            nn_q        <= '0;
            empty_q     <= 1'b0;
            msg_cnt_q   <= '0;
            fill_cnt_q  <= '0;
            drain_idx_q <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start_i) begin
                kk_q        <= kk_i;
                nn_q        <= nn_i;
                empty_q     <= empty_i;
                msg_cnt_q   <= '0;
                fill_cnt_q  <= '0;
                drain_idx_q <= '0;
                first_q     <= 1'b1;
                last_q      <= (kk_i == '0) & empty_i;
            end
            if (accept) begin
                fill_cnt_q <= fill_cnt_inc;
                if (state_q == ST_FILL) begin
                    msg_cnt_q <= msg_cnt_q + ONE_MSG;
                    if (in_last_i) begin
                        last_q <= 1'b1;
                    end
                end else if (key_done) begin
                    // The key block is last only when no message follows.
                    last_q <= empty_q;
                end
            end
            if (data_v_o) begin
                if (drain_at_end) begin
                    drain_idx_q <= '0;
                    fill_cnt_q  <= '0;
                    first_q     <= 1'b0;
                end else begin
                    drain_idx_q <= drain_idx_q + ONE_IDX;
                end
            end
        end
    end

endmodule

// File: doc/blake2_msg_pad.md
BLAKE2_MSG_PAD -- requirements
Module: blake2_msg_pad

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 64, giving the bytes per compression block.
REQ-002 SHALL have parameter IDX_W, default 6, giving the width of the block byte index.
REQ-003 SHALL have parameter KK_W, default 6, giving the width of the key and digest lengths.
REQ-004 SHALL have parameter LL_W, default 128, giving the width of the total length output.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start_i  in  1  pulse that begins a hash, honoured only in IDLE.
REQ-008 kk_i / nn_i / empty_i  in  KK_W / KK_W / 1  key bytes, digest bytes and zero-length-message flag, latched on start_i.
REQ-009 in_v_i / in_ready_o  in / out  1 / 1  byte-stream valid/ready; a transfer occurs when both are high.
REQ-010 in_data_i / in_last_i  in  8 / 1  byte value and final-message-byte marker.
REQ-011 core_ready_i  in  1  downstream core can accept a byte (combinational from core state).
REQ-012 data_v_o / data_idx_o / data_o  out  1 / IDX_W / 8  byte to core and its index within the block.
REQ-013 block_first_o / block_last_o  out  1 / 1  flags that are constant for every byte of a block.
REQ-014 kk_o / nn_o / ll_o  out  KK_W / KK_W / LL_W  latched lengths; ll_o is the byte count for the final t.

Function
REQ-015 FSM states SHALL be IDLE, KEY, FILL and DRAIN; the default/illegal state SHALL go to IDLE.
REQ-016 IDLE->KEY when start_i & kk_i!=0.
REQ-017 IDLE->DRAIN (zero block, last) when start_i & kk_i==0 & empty_i.
REQ-018 IDLE->FILL when start_i otherwise.
REQ-019 KEY: in_ready_o=1; accept exactly kk bytes into buf[0..kk-1]; in_last_i ignored; after byte kk go to DRAIN with last=empty.
REQ-020 FILL: in_ready_o=1; accept bytes into buf[fill_cnt]; go to DRAIN when fill_cnt reaches BLOCK_BYTES or on an accepted byte with in_last_i=1 (last=1).
REQ-021 A last byte arriving exactly at byte 64 SHALL give one full block with last=1 and no extra padding block.
REQ-022 DRAIN: in_ready_o=0; data_v_o = core_ready_i; data_idx_o = drain_idx 0..63.
REQ-023 In DRAIN, data_o SHALL be buf[idx] when idx<fill_cnt, else 8'h00; the buffer need not be cleared.
REQ-024 drain_idx SHALL advance only when data_v_o is high and SHALL hold while core_ready_i is low, so no byte is lost or duplicated.
REQ-025 After idx 63 is sent: last -> IDLE; otherwise -> FILL with fill_cnt=0.
REQ-026 block_first_o SHALL be 1 for the first block after start, 0 for every later block.
REQ-027 block_last_o SHALL equal the last flag of the block being drained.
REQ-028 A message byte counter (64 bits, wrapping) SHALL count accepted FILL bytes only.
REQ-029 ll_o SHALL be {zero-extend(msg_cnt)} + (kk!=0 ? BLOCK_BYTES : 0), stable from the first byte of the last block until the next start.
REQ-030 start_i outside IDLE SHALL be ignored; in_v_i in IDLE or DRAIN SHALL not be accepted.

Reset
REQ-031 On reset, asynchronously: state=IDLE, in_ready_o=0, data_v_o=0, data_idx_o=0, data_o=0, block_first_o=0, block_last_o=0, kk_o=0, nn_o=0, ll_o=0, all counters 0.
REQ-032 Reset mid-block SHALL abandon the hash; a new start_i is required afterwards.
REQ-033 The byte buffer SHALL need no reset.

Structure
REQ-034 A shared blake2 package SHALL hold BLOCK_BYTES, the index/length widths and the FSM state encodings.
REQ-035 The 64x8 byte buffer plus its zero-pad read mux SHALL be one sub-module, blake2_blk_buf; everything else stays flat.

Verification
REQ-036 Start kk=0 nn=64; bytes 61 62 63 with last on 63 -> 64 outputs idx 0..63 carrying 61 62 63 then 61x00; first=1 last=1 ll=3.
REQ-037 Start kk=0 empty=1 -> one all-zero block, first=last=1, ll=0; in_ready_o never 1.
REQ-038 64 bytes with last on byte 64 -> one block, last=1, ll=64; 65 bytes -> two blocks, block2 first=0 last=1 ll=65 with bytes 1..63 = 00.
REQ-039 Start kk=3 with key 01 02 03, then message AA with last -> block1 01 02 03+61x00 first=1 last=0; block2 AA+63x00 first=0 last=1 ll=65.
REQ-040 core_ready_i low for 5 cycles at idx 20 -> data_v_o low and idx held at 20; resumes at 20 with 64 total bytes delivered.
REQ-041 reset pulse at idx 30 of DRAIN -> all outputs 0 the same cycle; IDLE after release; no output until the next start_i.
